// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_write_arbiter
// Description : Shares the single shared_vram write port between NREQ write
//               requesters (CPU store path, fill engine, debug writer).
//               Round-robin grant, one word in flight, full wren/wrack
//               handshake, one-cycle done (and err) pulse per request.
//               FSM: IDLE -> WRITE -> RELEASE -> IDLE, all outputs registered.
// Option      : `define VRAM_WR_TIMEOUT_EN adds an 8-bit watchdog that
//               abandons a write after TIMEOUT cycles without vram_wrack.
// Ports       : clk          pll_out clock
//               reset_n      asynchronous active-low reset
//               req_valid    per-requester pending flag (held until done)
//               req_addr     packed addresses, requester i at [i*AW +: AW]
//               req_data     packed data,      requester i at [i*DW +: DW]
//               req_done     one-cycle completion pulse per requester
//               req_err      one-cycle error pulse (range reject / timeout)
//               vram_wren    shared_vram write enable
//               vram_waddr   shared_vram write address
//               vram_wdata   shared_vram write data
//               vram_wrack   shared_vram write-committed acknowledge
//               busy         high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module vram_write_arbiter #(
   parameter int NREQ       = 2,
   parameter int AW         = 14,
   parameter int DW         = 16,
   parameter int VRAM_WORDS = 8192,
   parameter int TIMEOUT    = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_done,
   output logic [NREQ-1:0]    req_err,
   output logic               vram_wren,
   output logic [AW-1:0]      vram_waddr,
   output logic [DW-1:0]      vram_wdata,
   input  logic               vram_wrack,
   output logic               busy
);

   localparam int          c_GW    = $clog2(NREQ);
   // One extra bit so VRAM_WORDS == 2**AW still compares correctly.
   localparam logic [AW:0] c_WORDS = (AW+1)'(VRAM_WORDS);

   if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("vram_write_arbiter: NREQ must be 2..4 and TIMEOUT 1..255");
   end

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t            r_state, w_state_n;
   logic [c_GW-1:0]   r_grant, w_grant_n;
   logic [c_GW-1:0]   r_last,  w_last_n;
   logic              r_wren,  w_wren_n;
   logic [AW-1:0]     r_waddr, w_waddr_n;
   logic [DW-1:0]     r_wdata, w_wdata_n;
   logic [NREQ-1:0]   r_done,  w_done_n;
   logic [NREQ-1:0]   r_err,   w_err_n;
   logic              r_busy,  w_busy_n;
`ifdef VRAM_WR_TIMEOUT_EN
   logic [7:0]        r_tmo,   w_tmo_n;
`endif

   logic [c_GW-1:0]   w_pick;
   logic [AW-1:0]     w_sel_addr;
   logic [DW-1:0]     w_sel_data;
   logic              w_in_range;
   logic [NREQ-1:0]   w_pick_oh;
   logic [NREQ-1:0]   w_grant_oh;

   // Round-robin: first valid index scanning last+1, last+2, ... (mod NREQ).
   // The scan ends on last itself, so a lone requester can win repeatedly.
   always_comb begin
      w_pick = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req_valid[(int'(r_last) + k) % NREQ]) begin
            w_pick = c_GW'((int'(r_last) + k) % NREQ);
         end
      end
   end

   assign w_sel_addr = req_addr[w_pick*AW +: AW];
   assign w_sel_data = req_data[w_pick*DW +: DW];
   assign w_in_range = ({1'b0, w_sel_addr} < c_WORDS);
   assign w_pick_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
   assign w_grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;

   always_comb begin
      w_state_n = r_state;
      w_grant_n = r_grant;
      w_last_n  = r_last;
      w_wren_n  = r_wren;
      w_waddr_n = r_waddr;
      w_wdata_n = r_wdata;
      w_done_n  = '0;
      w_err_n   = '0;
`ifdef VRAM_WR_TIMEOUT_EN
      w_tmo_n   = r_tmo;
`endif
      case (r_state)
         S_IDLE: begin
            if (|req_valid) begin
               w_grant_n = w_pick;
               if (w_in_range) begin
                  w_wren_n  = 1'b1;
                  w_waddr_n = w_sel_addr;
                  w_wdata_n = w_sel_data;
                  w_state_n = S_WRITE;
`ifdef VRAM_WR_TIMEOUT_EN
                  w_tmo_n   = 8'd0;
`endif
               end else begin
                  // Out-of-range: answer immediately, VRAM untouched.
                  w_done_n  = w_pick_oh;
                  w_err_n   = w_pick_oh;
                  w_last_n  = w_pick;
                  w_state_n = S_RELEASE;
               end
            end
         end
         S_WRITE: begin
            // wrack is checked first so it beats a coincident timeout.
            if (vram_wrack) begin
               w_wren_n  = 1'b0;
               w_done_n  = w_grant_oh;
               w_last_n  = r_grant;
               w_state_n = S_RELEASE;
            end
`ifdef VRAM_WR_TIMEOUT_EN
            else if (r_tmo == 8'(TIMEOUT - 1)) begin
               w_wren_n  = 1'b0;
               w_done_n  = w_grant_oh;
               w_err_n   = w_grant_oh;
               w_last_n  = r_grant;
               w_state_n = S_RELEASE;
            end else begin
               w_tmo_n   = r_tmo + 8'd1;
            end
`endif
         end
         S_RELEASE: begin
            // One dead cycle so the requester can drop req_valid.
            w_wren_n  = 1'b0;
            w_state_n = S_IDLE;
         end
         default: begin
            w_wren_n  = 1'b0;
            w_state_n = S_IDLE;
         end
      endcase
      w_busy_n = (w_state_n != S_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_last  <= c_GW'(NREQ - 1);
         r_wren  <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
         r_done  <= '0;
         r_err   <= '0;
         r_busy  <= 1'b0;
`ifdef VRAM_WR_TIMEOUT_EN
         r_tmo   <= 8'd0;
`endif
      end else begin
         r_state <= w_state_n;
         r_grant <= w_grant_n;
         r_last  <= w_last_n;
         r_wren  <= w_wren_n;
         r_waddr <= w_waddr_n;
         r_wdata <= w_wdata_n;
         r_done  <= w_done_n;
         r_err   <= w_err_n;
         r_busy  <= w_busy_n;
`ifdef VRAM_WR_TIMEOUT_EN
         r_tmo   <= w_tmo_n;
`endif
      end
   end

   assign vram_wren  = r_wren;
   assign vram_waddr = r_waddr;
   assign vram_wdata = r_wdata;
   assign req_done   = r_done;
   assign req_err    = r_err;
   assign busy       = r_busy;

endmodule
`default_nettype wire
